// File: rtl/uart_pkg.sv
// Shared UART constants: rate-option encoding, baud table and divisor helper.
package uart_pkg;

  localparam logic [1:0] OPT_9600   = 2'b00;
  localparam logic [1:0] OPT_19200  = 2'b01;
  localparam logic [1:0] OPT_57600  = 2'b10;
  localparam logic [1:0] OPT_115200 = 2'b11;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } tick_state_e;

  // Baud rate selected by a rate option.
  function automatic int unsigned opt_to_baud(input logic [1:0] opt);
    case (opt)
      OPT_9600:   return BAUD_9600;
      OPT_19200:  return BAUD_19200;
      OPT_57600:  return BAUD_57600;
      default:    return BAUD_115200;
    endcase
  endfunction

  // Clock cycles per oversampled tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned num;
    den = 64'(baud) * 64'(os);
    num = 64'(clk_hz) + den / 64'd2;
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/baud_div_rom.sv
// Maps the active rate option to its divisor D; also guards parameter ranges.
module baud_div_rom
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic [1:0]       i_opt,
  output logic [CNT_W-1:0] o_div
);

  localparam int unsigned D_9600   = baud_div(CLK_HZ, BAUD_9600, OVERSAMPLE);
  localparam int unsigned D_19200  = baud_div(CLK_HZ, BAUD_19200, OVERSAMPLE);
  localparam int unsigned D_57600  = baud_div(CLK_HZ, BAUD_57600, OVERSAMPLE);
  localparam int unsigned D_115200 = baud_div(CLK_HZ, BAUD_115200, OVERSAMPLE);

  localparam longint unsigned SLOW_DEN  = 64'(BAUD_9600) * 64'(OVERSAMPLE);
  localparam longint unsigned SLOW_CEIL = (64'(CLK_HZ) + SLOW_DEN - 64'd1) / SLOW_DEN;
  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  // The slowest rate must fit the counter; the fastest needs D >= 2 so
  // ticks can never land in consecutive cycles.
  if ((OVERSAMPLE < 2) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_os
    $error("baud_div_rom: OVERSAMPLE must be a power of two >= 2");
  end
  if (SLOW_CEIL > CNT_LIMIT) begin : g_bad_cnt_w
    $error("baud_div_rom: CNT_W too small for 9600 b/s divisor");
  end
  if (64'(D_9600) > CNT_LIMIT) begin : g_bad_round
    $error("baud_div_rom: rounded 9600 b/s divisor exceeds CNT_W");
  end
  if (D_115200 < 2) begin : g_bad_fast
    $error("baud_div_rom: 115200 b/s divisor below 2");
  end

  // Pure lookup of the divisor for the selected rate.
  always_comb begin
    o_div = CNT_W'(D_115200);
    case (i_opt)
      OPT_9600:   o_div = CNT_W'(D_9600);
      OPT_19200:  o_div = CNT_W'(D_19200);
      OPT_57600:  o_div = CNT_W'(D_57600);
      default:    o_div = CNT_W'(D_115200);
    endcase
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: single-cycle rx/mid/tx enables plus legacy baud_clk,
// with bit-phase resync and rate changes deferred to bit boundaries.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [1:0] usr_option,
  input  logic       enable,
  input  logic       resync,
  output logic       rx_tick,
  output logic       mid_tick,
  output logic       tx_tick,
  output logic       baud_clk
);

  localparam int unsigned SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

  tick_state_e      r_state;
  tick_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [SUB_W-1:0] r_sub_cnt;
  logic [SUB_W-1:0] w_sub_nxt;
  logic [1:0]       r_active_opt;
  logic [1:0]       w_opt_nxt;
  logic             r_rx_tick, r_mid_tick, r_tx_tick, r_baud_clk;
  logic             w_rx_nxt, w_mid_nxt, w_tx_nxt, w_baud_nxt;
  logic [CNT_W-1:0] w_div;
  logic [CNT_W-1:0] w_div_last;
  logic             w_wrap;

  baud_div_rom #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_div_rom (
    .i_opt (r_active_opt),
    .o_div (w_div)
  );

  assign w_div_last = w_div - CNT_W'(1);
  assign w_wrap     = (r_div_cnt == w_div_last);

  // Next-state and next-register values; disable beats resync beats counting.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt + CNT_W'(1);
    w_sub_nxt   = r_sub_cnt;
    w_opt_nxt   = r_active_opt;
    w_rx_nxt    = 1'b0;
    w_mid_nxt   = 1'b0;
    w_tx_nxt    = 1'b0;
    w_baud_nxt  = r_baud_clk;

    case (r_state)
      S_IDLE:  if (enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (!enable) begin
      w_div_nxt  = '0;
      w_sub_nxt  = '0;
      w_baud_nxt = 1'b0;
      w_opt_nxt  = usr_option;
    end else if (resync) begin
      // Restart the bit phase; any coincident wrap is swallowed.
      w_div_nxt  = '0;
      w_sub_nxt  = '0;
      w_baud_nxt = 1'b0;
      w_opt_nxt  = usr_option;
    end else if (w_wrap) begin
      w_div_nxt = '0;
      w_rx_nxt  = 1'b1;
      w_sub_nxt = (r_sub_cnt == SUB_LAST) ? '0 : r_sub_cnt + SUB_W'(1);
      if (r_sub_cnt == SUB_MID) begin
        w_mid_nxt  = 1'b1;
        w_baud_nxt = ~r_baud_clk;
      end
      if (r_sub_cnt == SUB_LAST) begin
        // Bit boundary: the only point where a new rate is adopted.
        w_tx_nxt   = 1'b1;
        w_baud_nxt = ~r_baud_clk;
        w_opt_nxt  = usr_option;
      end
    end
  end

  // State, counter and output registers with synchronous reset to IDLE.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_active_opt <= usr_option;
      r_rx_tick    <= 1'b0;
      r_mid_tick   <= 1'b0;
      r_tx_tick    <= 1'b0;
      r_baud_clk   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div_cnt    <= w_div_nxt;
      r_sub_cnt    <= w_sub_nxt;
      r_active_opt <= w_opt_nxt;
      r_rx_tick    <= w_rx_nxt;
      r_mid_tick   <= w_mid_nxt;
      r_tx_tick    <= w_tx_nxt;
      r_baud_clk   <= w_baud_nxt;
    end
  end

  assign rx_tick  = r_rx_tick;
  assign mid_tick = r_mid_tick;
  assign tx_tick  = r_tx_tick;
  assign baud_clk = r_baud_clk;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 50 MHz, OVERSAMPLE = 16.
// Outputs are compared as the nibble {rx_tick, mid_tick, tx_tick, baud_clk}.
module tb_baud_tick_gen;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       resync = 1'b0;
  logic [1:0] usr_option = 2'b00;
  logic       rx_tick, mid_tick, tx_tick, baud_clk;

  baud_tick_gen #(
    .CLK_HZ     (50_000_000),
    .OVERSAMPLE (16),
    .CNT_W      (16)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .usr_option (usr_option),
    .enable     (enable),
    .resync     (resync),
    .rx_tick    (rx_tick),
    .mid_tick   (mid_tick),
    .tx_tick    (tx_tick),
    .baud_clk   (baud_clk)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] opt;
    int         edges;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   edge_no = 0;

  function automatic logic [31:0] outs();
    return {28'd0, rx_tick, mid_tick, tx_tick, baud_clk};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] opt, input int edges, input logic [3:0] exp,
                         input string name);
    vec_t v;
    v.opt = opt; v.edges = edges; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge sys_clk);
    #1;
    edge_no++;
  endtask

  task automatic run_to(input int n);
    while (edge_no < n) step();
  endtask

  // Reset with the given option, then release so the next edge is edge 1.
  task automatic start_run(input logic [1:0] opt);
    reset = 1'b1; enable = 1'b0; resync = 1'b0; usr_option = opt;
    step();
    step();
    reset = 1'b0; enable = 1'b1;
    edge_no = 0;
  endtask

  int rxc, midc, txc, hic, anyc;

  initial begin
    // {rx, mid, tx, baud} after a given number of qualifying edges.
    add_vec(2'b11,   26, 4'b0000, "opt11_e26");
    add_vec(2'b11,   27, 4'b1000, "opt11_e27");
    add_vec(2'b11,   28, 4'b0000, "opt11_e28");
    add_vec(2'b11,  215, 4'b0000, "opt11_e215");
    add_vec(2'b11,  216, 4'b1101, "opt11_e216");
    add_vec(2'b11,  217, 4'b0001, "opt11_e217");
    add_vec(2'b11,  431, 4'b0001, "opt11_e431");
    add_vec(2'b11,  432, 4'b1010, "opt11_e432");
    add_vec(2'b11,  433, 4'b0000, "opt11_e433");
    add_vec(2'b01,  163, 4'b1000, "opt01_e163");
    add_vec(2'b01, 1304, 4'b1101, "opt01_e1304");
    add_vec(2'b10,   54, 4'b1000, "opt10_e54");
    add_vec(2'b10,  864, 4'b1010, "opt10_e864");
    add_vec(2'b00,  325, 4'b0000, "opt00_e325");
    add_vec(2'b00,  326, 4'b1000, "opt00_e326");
    add_vec(2'b00, 2608, 4'b1101, "opt00_e2608");

    // Reset state from power-up.
    step();
    step();
    check("reset_state", outs(), 32'h0);

    foreach (vq[i]) begin
      start_run(vq[i].opt);
      run_to(vq[i].edges);
      check(vq[i].name, outs(), {28'd0, vq[i].exp});
    end

    // Two full bits at 115200: tick counts and baud_clk duty.
    start_run(2'b11);
    rxc = 0; midc = 0; txc = 0; hic = 0;
    for (int i = 0; i < 864; i++) begin
      step();
      rxc += int'(rx_tick); midc += int'(mid_tick); txc += int'(tx_tick); hic += int'(baud_clk);
    end
    check("t1_rx_count", rxc, 32);
    check("t1_mid_count", midc, 2);
    check("t1_tx_count", txc, 2);
    check("t1_baud_high", hic, 432);

    // Ten bits at 9600.
    start_run(2'b00);
    rxc = 0; midc = 0; txc = 0;
    for (int i = 0; i < 52160; i++) begin
      step();
      rxc += int'(rx_tick); midc += int'(mid_tick); txc += int'(tx_tick);
    end
    check("t2_rx_count", rxc, 160);
    check("t2_mid_count", midc, 10);
    check("t2_tx_count", txc, 10);

    // Rate change mid-bit is deferred to the bit boundary.
    start_run(2'b11);
    run_to(99);
    usr_option = 2'b10;
    run_to(405);
    check("t3_old_rate_e405", outs(), 32'h9);
    run_to(432);
    check("t3_tx_e432", outs(), 32'ha);
    run_to(459);
    check("t3_no_rx_e459", outs(), 32'h0);
    run_to(486);
    check("t3_new_rx_e486", outs(), 32'h8);
    rxc = 0; txc = 0;
    while (edge_no < 1296) begin
      step();
      rxc += int'(rx_tick); txc += int'(tx_tick);
    end
    check("t3_rx_count", rxc, 15);
    check("t3_tx_count", txc, 1);
    check("t3_tx_e1296", outs(), 32'ha);

    // Resync at edge 200.
    start_run(2'b11);
    run_to(199);
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("t4_resync_cycle", outs(), 32'h0);
    anyc = 0;
    while (edge_no < 226) begin
      step();
      anyc += int'(rx_tick) + int'(mid_tick) + int'(tx_tick);
    end
    check("t4_quiet_to_226", anyc, 0);
    run_to(227);
    check("t4_rx_e227", outs(), 32'h8);
    run_to(416);
    check("t4_mid_e416", outs(), 32'hd);
    run_to(631);
    check("t4_e631", outs(), 32'h1);
    run_to(632);
    check("t4_tx_e632", outs(), 32'ha);

    // Resync landing on a wrap edge swallows the tick.
    start_run(2'b11);
    run_to(269);
    check("t4b_e269", outs(), 32'h1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("t4b_wrap_suppressed", outs(), 32'h0);
    run_to(296);
    check("t4b_e296", outs(), 32'h0);
    run_to(297);
    check("t4b_rx_e297", outs(), 32'h8);

    // Enable dropped while baud_clk is high, then re-enabled at a new rate.
    start_run(2'b11);
    run_to(299);
    enable = 1'b0;
    usr_option = 2'b10;
    step();
    check("t5_disabled", outs(), 32'h0);
    anyc = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      anyc += int'(rx_tick) + int'(mid_tick) + int'(tx_tick) + int'(baud_clk);
    end
    check("t5_held_clear", anyc, 0);
    enable = 1'b1;
    edge_no = 0;
    run_to(27);
    check("t5_no_old_rate_e27", outs(), 32'h0);
    run_to(54);
    check("t5_rx_e54", outs(), 32'h8);

    // Reset mid-bit with a pending rate change.
    start_run(2'b11);
    run_to(220);
    usr_option = 2'b00;
    run_to(230);
    check("t6_before_reset", outs(), 32'h1);
    reset = 1'b1;
    step();
    check("t6_reset_now", outs(), 32'h0);
    step();
    check("t6_reset_hold", outs(), 32'h0);
    reset = 1'b0;
    edge_no = 0;
    anyc = 0;
    while (edge_no < 325) begin
      step();
      anyc += int'(rx_tick) + int'(mid_tick) + int'(tx_tick) + int'(baud_clk);
    end
    check("t6_no_stale", anyc, 0);
    run_to(326);
    check("t6_rx_e326", outs(), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
